// File: rtl/bus_transfer_scheduler.sv
// bus_transfer_scheduler
//   Round-robin scheduler for register-to-register moves over a shared
//   tri-state bus. Each grant runs IDLE -> DRIVE -> LOAD -> ACK, driving the
//   active-low enablebar/loadbar strobes of the bus registers so that at most
//   one register drives the bus at any time. All outputs are registered.
//   Optional build macro BUS_XFER_CHECK_EN adds an err output and rejects
//   grants with src==dst or an out-of-range register index.
module bus_transfer_scheduler #(
    parameter int NREG = 8,
    parameter int NREQ = 4,
    parameter int SELW = 3,
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*SELW-1:0] req_src,
    input  logic [NREQ*SELW-1:0] req_dst,
    output logic [NREQ-1:0]      ack,
    output logic [NREG-1:0]      enablebar,
    output logic [NREG-1:0]      loadbar,
    output logic                 busy,
`ifdef BUS_XFER_CHECK_EN
    output logic                 err,
`endif
    output logic [GW-1:0]        grant_id
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_LOAD,
        S_ACK
    } state_t;

    state_t          state_q, state_d;
    logic [SELW-1:0] src_q, src_d;
    logic [SELW-1:0] dst_q, dst_d;
    logic [GW-1:0]   gid_q, gid_d;
    logic [GW-1:0]   rr_q, rr_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREG-1:0] eb_q, eb_d;
    logic [NREG-1:0] lb_q, lb_d;
    logic            busy_q, busy_d;

    logic            found;
    logic [GW-1:0]   pick_id;
    logic [SELW-1:0] pick_src;
    logic [SELW-1:0] pick_dst;
    int unsigned     scan_idx;

`ifdef BUS_XFER_CHECK_EN
    logic            err_q, err_d;
    logic            pick_src_ok;
    logic            pick_dst_ok;
    logic            pick_bad;
`endif

    // Round-robin successor of a requester index, wrapping at NREQ.
    function automatic logic [GW-1:0] rr_after(input logic [GW-1:0] g);
        if (g == GW'(NREQ - 1)) return '0;
        return g + GW'(1);
    endfunction

    // Find the first requester at or after the rr pointer and its indices.
    always_comb begin
        found    = 1'b0;
        pick_id  = '0;
        pick_src = '0;
        pick_dst = '0;
        scan_idx = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = (32'(rr_q) + k) % NREQ;
            if (!found && req[scan_idx]) begin
                found    = 1'b1;
                pick_id  = GW'(scan_idx);
                pick_src = req_src[scan_idx*SELW +: SELW];
                pick_dst = req_dst[scan_idx*SELW +: SELW];
            end
        end
    end

`ifdef BUS_XFER_CHECK_EN
    // Classify the candidate grant as illegal (self-move or unknown register).
    always_comb begin
        pick_src_ok = 1'b0;
        pick_dst_ok = 1'b0;
        for (int unsigned r = 0; r < NREG; r++) begin
            if (pick_src == SELW'(r)) pick_src_ok = 1'b1;
            if (pick_dst == SELW'(r)) pick_dst_ok = 1'b1;
        end
        pick_bad = (pick_src == pick_dst) || !pick_src_ok || !pick_dst_ok;
    end
`endif

    // Next state, latched transfer fields, ack pulse and rr pointer update.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        gid_d   = gid_q;
        rr_d    = rr_q;
        ack_d   = '0;
`ifdef BUS_XFER_CHECK_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gid_d   = pick_id;
                    src_d   = pick_src;
                    dst_d   = pick_dst;
                    state_d = S_DRIVE;
`ifdef BUS_XFER_CHECK_EN
                    if (pick_bad) begin
                        state_d        = S_ACK;
                        ack_d[pick_id] = 1'b1;
                        err_d          = 1'b1;
                        rr_d           = rr_after(pick_id);
                    end
`endif
                end
            end
            S_DRIVE: state_d = S_LOAD;
            S_LOAD: begin
                state_d      = S_ACK;
                ack_d[gid_q] = 1'b1;
                rr_d         = rr_after(gid_q);
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus strobes are decoded from the state being entered so they register
    // in step with it; an index with no matching register drives nothing.
    always_comb begin
        eb_d = '1;
        lb_d = '1;
        for (int unsigned r = 0; r < NREG; r++) begin
            if ((state_d == S_DRIVE || state_d == S_LOAD) && src_d == SELW'(r))
                eb_d[r] = 1'b0;
            if (state_d == S_LOAD && dst_d == SELW'(r))
                lb_d[r] = 1'b0;
        end
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset releases the bus immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            gid_q   <= '0;
            rr_q    <= '0;
            ack_q   <= '0;
            eb_q    <= '1;
            lb_q    <= '1;
            busy_q  <= 1'b0;
`ifdef BUS_XFER_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            gid_q   <= gid_d;
            rr_q    <= rr_d;
            ack_q   <= ack_d;
            eb_q    <= eb_d;
            lb_q    <= lb_d;
            busy_q  <= busy_d;
`ifdef BUS_XFER_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign ack       = ack_q;
    assign enablebar = eb_q;
    assign loadbar   = lb_q;
    assign busy      = busy_q;
    assign grant_id  = gid_q;
`ifdef BUS_XFER_CHECK_EN
    assign err       = err_q;
`endif

endmodule

// File: tb/tb_bus_transfer_scheduler.sv
// Testbench for bus_transfer_scheduler: transaction-level reference model
// (grant time + age of the current move), a small bus register file, directed
// scenarios with literal expectations and a constrained-random phase.
module tb_bus_transfer_scheduler;

    localparam int NREG = 8;
    localparam int NREQ = 4;
    localparam int SELW = 3;
    localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic                 clk  = 1'b0;
    logic                 rstn = 1'b1;
    logic [NREQ-1:0]      req;
    logic [NREQ*SELW-1:0] req_src;
    logic [NREQ*SELW-1:0] req_dst;
    logic [NREQ-1:0]      ack;
    logic [NREG-1:0]      enablebar;
    logic [NREG-1:0]      loadbar;
    logic                 busy;
    logic [GW-1:0]        grant_id;
`ifdef BUS_XFER_CHECK_EN
    logic                 err;
`endif

    bus_transfer_scheduler #(.NREG(NREG), .NREQ(NREQ), .SELW(SELW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req),
        .req_src   (req_src),
        .req_dst   (req_dst),
        .ack       (ack),
        .enablebar (enablebar),
        .loadbar   (loadbar),
        .busy      (busy),
`ifdef BUS_XFER_CHECK_EN
        .err       (err),
`endif
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    // ---------------- bus register file ----------------
    logic [7:0] regs [NREG] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    logic [7:0] bus_val;

    always_comb begin
        bus_val = '0;
        for (int i = 0; i < NREG; i++)
            if (!enablebar[i]) bus_val = regs[i];
    end

    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++)
            if (!loadbar[i]) regs[i] <= bus_val;
    end

    // ---------------- reference model ----------------
    // m_age: 0 = no transfer, 1 = bus driven, 2 = bus driven + dst loading,
    // 3 = acknowledge cycle.
    int              m_age    = 0;
    int              m_rr     = 0;
    int              m_grants = 0;
    logic [GW-1:0]   m_gid    = '0;
    logic [SELW-1:0] m_src    = '0;
    logic [SELW-1:0] m_dst    = '0;
    logic            m_bad    = 1'b0;

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int rr);
        for (int k = 0; k < NREQ; k++)
            if (r[(rr + k) % NREQ]) return (rr + k) % NREQ;
        return 0;
    endfunction

    function automatic logic illegal(input logic [SELW-1:0] s, input logic [SELW-1:0] d);
        return (s == d) || (int'(s) >= NREG) || (int'(d) >= NREG);
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_age <= 0;
            m_rr  <= 0;
            m_gid <= '0;
            m_src <= '0;
            m_dst <= '0;
            m_bad <= 1'b0;
        end else if (m_age != 0) begin
            m_age <= (m_age == 3) ? 0 : m_age + 1;
        end else if (req != '0) begin
            m_gid    <= GW'(rr_pick(req, m_rr));
            m_src    <= req_src[rr_pick(req, m_rr)*SELW +: SELW];
            m_dst    <= req_dst[rr_pick(req, m_rr)*SELW +: SELW];
            m_rr     <= (rr_pick(req, m_rr) + 1) % NREQ;
            m_grants <= m_grants + 1;
`ifdef BUS_XFER_CHECK_EN
            m_bad <= illegal(req_src[rr_pick(req, m_rr)*SELW +: SELW],
                             req_dst[rr_pick(req, m_rr)*SELW +: SELW]);
            m_age <= illegal(req_src[rr_pick(req, m_rr)*SELW +: SELW],
                             req_dst[rr_pick(req, m_rr)*SELW +: SELW]) ? 3 : 1;
`else
            m_bad <= 1'b0;
            m_age <= 1;
`endif
        end
    end

    logic [NREG-1:0] exp_eb, exp_lb;
    logic [NREQ-1:0] exp_ack;
    logic            exp_busy;
    logic [GW-1:0]   exp_gid;
    logic            exp_err;

    always_comb begin
        exp_eb   = '1;
        exp_lb   = '1;
        exp_ack  = '0;
        exp_busy = (m_age != 0);
        exp_gid  = m_gid;
        exp_err  = (m_age == 3) && m_bad;
        if ((m_age == 1 || m_age == 2) && int'(m_src) < NREG) exp_eb[m_src] = 1'b0;
        if (m_age == 2 && int'(m_dst) < NREG) exp_lb[m_dst] = 1'b0;
        if (m_age == 3) exp_ack[m_gid] = 1'b1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if ({enablebar, loadbar, ack, busy, grant_id} !==
                {exp_eb, exp_lb, exp_ack, exp_busy, exp_gid}) begin
                n_errors++;
                $display("FAIL model t=%0t enablebar=%h/%h loadbar=%h/%h ack=%b/%b busy=%b/%b grant_id=%0d/%0d (got/expected)",
                         $time, enablebar, exp_eb, loadbar, exp_lb, ack, exp_ack, busy, exp_busy, grant_id, exp_gid);
            end
`ifdef BUS_XFER_CHECK_EN
            n_checks++;
            if (err !== exp_err) begin
                n_errors++;
                $display("FAIL err t=%0t got %b expected %b", $time, err, exp_err);
            end
`endif
            n_checks++;
            if ($countones(~enablebar) > 1 || $countones(~loadbar) > 1 || $countones(ack) > 1 ||
                (loadbar != '1 && enablebar == '1)) begin
                n_errors++;
                $display("FAIL exclusivity t=%0t got enablebar=%h loadbar=%h ack=%b expected at most one low/high bit each",
                         $time, enablebar, loadbar, ack);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [NREG-1:0] s_eb, s_lb;
    logic [NREQ-1:0] s_ack;
    logic            s_busy;
    logic [GW-1:0]   s_gid;
`ifdef BUS_XFER_CHECK_EN
    logic            s_err;
`endif
    logic [NREQ-1:0] pend_drop = '0;
    int              n_ack_seen = 0;
    logic [NREQ-1:0] ack_log [$];

    // Sample outputs mid-cycle, then advance to just after the next posedge;
    // a requester that saw its ack drops req in the following cycle.
    task automatic tick();
        @(negedge clk);
        s_eb   = enablebar;
        s_lb   = loadbar;
        s_ack  = ack;
        s_busy = busy;
        s_gid  = grant_id;
`ifdef BUS_XFER_CHECK_EN
        s_err  = err;
`endif
        pend_drop  = ack;
        n_ack_seen += $countones(ack);
        if (ack != '0) ack_log.push_back(ack);
        @(posedge clk);
        #1;
        req = req & ~pend_drop;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got time limit expired expected bench completion");
        $fatal(1, "watchdog expired");
    end

    int g0, a0;

    initial begin
        req     = '1;
        req_src = '0;
        req_dst = '0;
        #1 rstn = 1'b0;

        // Reset held with every requester asking.
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        chk("rst_enablebar", 32'(s_eb), 'hFF);
        chk("rst_loadbar", 32'(s_lb), 'hFF);
        chk("rst_ack", 32'(s_ack), 'h0);
        chk("rst_busy", 32'(s_busy), 'h0);
        chk("rst_grant_id", 32'(s_gid), 'h0);
        req  = '0;
        rstn = 1'b1;

        // Single transfer: requester 0 moves register 2 into register 5.
        req_src[0*SELW +: SELW] = 3'd2;
        req_dst[0*SELW +: SELW] = 3'd5;
        req = 4'b0001;
        tick();
        chk("single_idle_busy", 32'(s_busy), 'h0);
        tick();
        chk("single_drive_eb", 32'(s_eb), 'hFB);
        chk("single_drive_lb", 32'(s_lb), 'hFF);
        chk("single_drive_gid", 32'(s_gid), 'h0);
        tick();
        chk("single_load_eb", 32'(s_eb), 'hFB);
        chk("single_load_lb", 32'(s_lb), 'hDF);
        chk("single_load_ack", 32'(s_ack), 'h0);
        tick();
        chk("single_ack_eb", 32'(s_eb), 'hFF);
        chk("single_ack_lb", 32'(s_lb), 'hFF);
        chk("single_ack", 32'(s_ack), 'h1);
        tick();
        chk("single_done_busy", 32'(s_busy), 'h0);
        chk("single_reg5", 32'(regs[5]), 'h12);

        // Asynchronous reset while requester 2 is loading register 7.
        req_src[2*SELW +: SELW] = 3'd0;
        req_dst[2*SELW +: SELW] = 3'd7;
        req = 4'b0100;
        tick();
        tick();
        chk("areset_pre_eb", 32'(enablebar), 'hFE);
        chk("areset_pre_lb", 32'(loadbar), 'h7F);
        #2 rstn = 1'b0;
        #1;
        chk("areset_eb", 32'(enablebar), 'hFF);
        chk("areset_lb", 32'(loadbar), 'hFF);
        chk("areset_busy", 32'(busy), 'h0);
        req = '0;
        tick();
        tick();
        rstn = 1'b1;
        chk("areset_reg7_kept", 32'(regs[7]), 'h17);

        // Round robin with everyone requesting (self-moves keep regs intact).
        req_src = {3'd3, 3'd2, 3'd1, 3'd0};
        req_dst = {3'd3, 3'd2, 3'd1, 3'd0};
        ack_log.delete();
        req = 4'b1111;
        for (int t = 0; t < 40 && ack_log.size() < 4; t++) tick();
        chk("rr_count4", 32'(ack_log.size()), 4);
        if (ack_log.size() >= 4) begin
            chk("rr_order0", 32'(ack_log[0]), 'h1);
            chk("rr_order1", 32'(ack_log[1]), 'h2);
            chk("rr_order2", 32'(ack_log[2]), 'h4);
            chk("rr_order3", 32'(ack_log[3]), 'h8);
        end
        req = 4'b1001;
        for (int t = 0; t < 40 && ack_log.size() < 6; t++) tick();
        chk("rr_count6", 32'(ack_log.size()), 6);
        if (ack_log.size() >= 6) begin
            chk("rr_restart0", 32'(ack_log[4]), 'h1);
            chk("rr_restart1", 32'(ack_log[5]), 'h8);
        end

        // Source index and req change after grant must be ignored.
        req_src[1*SELW +: SELW] = 3'd1;
        req_dst[1*SELW +: SELW] = 3'd4;
        req = 4'b0010;
        tick();
        req_src[1*SELW +: SELW] = 3'd6;
        req = '0;
        tick();
        chk("mid_drive_eb", 32'(s_eb), 'hFD);
        chk("mid_drive_gid", 32'(s_gid), 'h1);
        tick();
        chk("mid_load_eb", 32'(s_eb), 'hFD);
        chk("mid_load_lb", 32'(s_lb), 'hEF);
        tick();
        chk("mid_ack", 32'(s_ack), 'h2);
        tick();
        chk("mid_reg4", 32'(regs[4]), 'h11);

        // src == dst on requester 3.
        req_src[3*SELW +: SELW] = 3'd3;
        req_dst[3*SELW +: SELW] = 3'd3;
        req = 4'b1000;
        tick();
`ifdef BUS_XFER_CHECK_EN
        tick();
        chk("self_eb", 32'(s_eb), 'hFF);
        chk("self_lb", 32'(s_lb), 'hFF);
        chk("self_ack", 32'(s_ack), 'h8);
        chk("self_err", 32'(s_err), 'h1);
        tick();
        chk("self_done_busy", 32'(s_busy), 'h0);
`else
        tick();
        chk("self_drive_eb", 32'(s_eb), 'hF7);
        chk("self_drive_lb", 32'(s_lb), 'hFF);
        tick();
        chk("self_load_eb", 32'(s_eb), 'hF7);
        chk("self_load_lb", 32'(s_lb), 'hF7);
        tick();
        chk("self_ack", 32'(s_ack), 'h8);
        tick();
        chk("self_reg3", 32'(regs[3]), 'h13);
`endif

        // Random contention.
        g0 = m_grants;
        a0 = n_ack_seen;
        for (int c = 0; c < 2000; c++) begin
            tick();
            req_src = (NREQ*SELW)'($urandom);
            req_dst = (NREQ*SELW)'($urandom);
            for (int i = 0; i < NREQ; i++)
                if (!req[i] && !pend_drop[i] && $urandom_range(0, 2) == 0) req[i] = 1'b1;
        end
        req = '0;
        repeat (8) tick();
        chk("ack_per_grant", 32'(n_ack_seen - a0), 32'(m_grants - g0));
        chk("random_idle", 32'(s_busy), 'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_transfer_scheduler.md
Name: bus_transfer_scheduler

Overview:
Arbitrates between several requesters that want to move a word over the shared tri-state bus, from one bus register to another. It sequences the active-low enablebar/loadbar controls of NREG bus registers so that only one register drives the bus at a time. Each granted request becomes a fixed 4-cycle transfer: drive, load, acknowledge, return to idle. It sits between the control/microcode logic and the register file on the shared bus.

Parameters:
NREG, 8, number of bus registers controlled (one enablebar and one loadbar bit each)
NREQ, 4, number of requesters
SELW, 3, width of a register index; must satisfy 2**SELW >= NREG

Ports:
clk  input  1  system clock; all state updates on posedge
rstn  input  1  asynchronous, active-low reset
req  input  NREQ  per-requester transfer request; level, held until ack
req_src  input  NREQ*SELW  packed source register index; slice i belongs to requester i
req_dst  input  NREQ*SELW  packed destination register index; slice i belongs to requester i
ack  output  NREQ  one-cycle completion pulse to the granted requester
enablebar  output  NREG  active-low bus drive enable, one bit per register
loadbar  output  NREG  active-low load enable, one bit per register
busy  output  1  high whenever state is not IDLE
grant_id  output  SELW-wide enough for NREQ (clog2(NREQ), min 1)  index of the current/last granted requester

Behaviour:
- All outputs are registered. Reset (async, rstn=0) forces: enablebar all 1, loadbar all 1, ack 0, busy 0, grant_id 0, rr pointer 0, state IDLE. This takes effect immediately, mid-transfer included; no partial load completes after reset asserts.
- FSM states: IDLE, DRIVE, LOAD, ACK.
- IDLE: if any req bit is set at a posedge, grant the first set bit at or after the rr pointer, wrapping modulo NREQ. Latch that requester's src/dst and grant_id, then go to DRIVE. With no req, stay in IDLE.
- DRIVE: enablebar[src]=0, all loadbar 1. Gives the bus one cycle to settle. Next state is LOAD.
- LOAD: enablebar[src]=0 and loadbar[dst]=0. The destination captures the bus on the posedge that ends LOAD. Next state is ACK.
- ACK: all enablebar/loadbar 1, ack[grant_id]=1 for exactly this cycle. The rr pointer becomes (grant_id+1) mod NREQ. Next state is IDLE.
- Timing: req sampled at edge T0 gives DRIVE after T0, LOAD after T1, dst capture at T2, ack high after T2, IDLE after T3. Back-to-back transfers run at one per 4 cycles (the IDLE cycle is included in the 4).
- At most one enablebar bit is ever low. No loadbar bit is low outside LOAD.
- src/dst are latched at grant, so changes on req_src/req_dst after grant are ignored. Dropping req mid-transfer does not abort; ack still pulses.
- A requester must drop req in the cycle after ack. A req still high in the next IDLE is treated as a new request.
- Index >= NREG: the corresponding bar is not asserted (no bit driven low); the transfer still completes and acks.
- src==dst is legal: the register reloads its own value.
- busy = (state != IDLE).

Optional Feature:
Macro BUS_XFER_CHECK_EN.
- Defined: adds output port err (1 bit, reset 0). A grant with src==dst, src>=NREG or dst>=NREG is rejected. The FSM goes IDLE -> ACK directly, asserts no bars, and pulses err=1 together with ack.
- Undefined: the err port is absent and all such transfers follow the normal rules above.

Test Plan:
- Reset: hold rstn=0 with req=4'b1111 -> enablebar=8'hFF, loadbar=8'hFF, ack=0, busy=0. Assert rstn=0 during LOAD -> bars go to 8'hFF immediately, without waiting for clk.
- Single transfer: req[0]=1, src=2, dst=5 -> enablebar=8'hFB for 2 cycles, loadbar=8'hDF for 1 cycle, ack=4'b0001 on cycle 4. Destination register 5 holds register 2's value.
- Round robin: req=4'b1111 held, each requester drops req after its ack -> grant order 0,1,2,3. Restarting with req=4'b1001 after that grants 0 then 3.
- Contention check: random req/src/dst for 2000 cycles -> popcount(~enablebar)<=1 every cycle, loadbar low only in LOAD, exactly one ack per grant.
- Mid-transfer changes: change req_src from 1 to 6 and drop req during DRIVE -> transfer still uses src=1, and ack still pulses.
- With BUS_XFER_CHECK_EN: src=3, dst=3 -> no bar asserted, ack and err pulse together 2 cycles after grant. Without the macro: the same stimulus gives a normal 4-cycle transfer.
